// File: rtl/control_if.sv
// control_if: push-button inputs and LED output of the counter controller
interface control_if;
    logic       button_0;
    logic       button_1;
    logic [2:0] led;
    modport master (output button_0, output button_1, input led);
    modport slave  (input button_0, input button_1, output led);
endinterface

// File: rtl/control.sv
// control: debounced two-button counter (button_1 increments, button_0 clears) shown on 3 LEDs
module control #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter bit LED_ACTIVE_LOW  = 0
) (
    input logic      clk,
    input logic      rst_n,
    control_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] raw, ev;
    logic [2:0] count, count_next, led_r;
    assign raw = {bus.button_1, bus.button_0};
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic s1, s2, db, db_q, ev_r;
        logic [CW-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1   <= 1'b1;
                s2   <= 1'b1;
                db   <= 1'b1;
                db_q <= 1'b1;
                ev_r <= 1'b0;
                cnt  <= '0;
            end else begin
                s1   <= raw[i];
                s2   <= s1;
                db_q <= db;
                ev_r <= db_q & ~db;
                if (s2 == db) cnt <= '0;
                else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                    db  <= s2;
                    cnt <= '0;
                end else cnt <= cnt + 1'b1;
            end
        end
        assign ev[i] = ev_r;
    end
    // clear takes priority over increment when both events coincide
    always_comb count_next = ev[0] ? 3'd0 : ev[1] ? count + 3'd1 : count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            led_r <= LED_ACTIVE_LOW ? 3'b111 : 3'b000;
        end else begin
            count <= count_next;
            led_r <= LED_ACTIVE_LOW ? ~count_next : count_next;
        end
    end
    assign bus.led = led_r;
endmodule

// File: tb/tb_control.sv
// tb_control: directed checks of debounce, latency, wrap, clear priority and async reset
module tb_control;
    logic clk = 0;
    logic rst_n = 0;
    int passed = 0;
    int total = 0;
    control_if bus ();
    control #(.DEBOUNCE_CYCLES(3), .LED_ACTIVE_LOW(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp);
        total++;
        assert (bus.led === exp) passed++;
        else $error("FAIL %s: led=%b expected=%b", tag, bus.led, exp);
    endtask

    task automatic press1(input int n);
        bus.button_1 = 0;
        tick(n);
        bus.button_1 = 1;
        tick(12);
    endtask

    task automatic press0(input int n);
        bus.button_0 = 0;
        tick(n);
        bus.button_0 = 1;
        tick(12);
    endtask

    initial begin
        bus.button_0 = 1;
        bus.button_1 = 1;
        tick(2);
        chk("reset", 3'b000);
        rst_n = 1;
        tick(100);
        chk("idle", 3'b000);
        bus.button_1 = 0;
        tick(5);
        bus.button_1 = 1;
        tick(2);
        chk("latency_k6", 3'b000);
        tick(1);
        chk("latency_k7", 3'b001);
        tick(30);
        chk("after_release", 3'b001);
        press0(5);
        chk("clear", 3'b000);
        bus.button_1 = 0;
        tick(50);
        chk("held_once", 3'b001);
        bus.button_1 = 1;
        tick(20);
        chk("held_release", 3'b001);
        press0(5);
        chk("clear2", 3'b000);
        for (int i = 1; i <= 9; i++) begin
            press1(5);
            chk($sformatf("inc%0d", i), 3'(i % 8));
        end
        press1(2);
        chk("glitch2", 3'b001);
        press1(3);
        chk("glitch3", 3'b001);
        press1(4);
        chk("pulse4", 3'b010);
        press1(5);
        press1(5);
        press1(5);
        chk("count5", 3'b101);
        bus.button_0 = 0;
        bus.button_1 = 0;
        tick(5);
        bus.button_0 = 1;
        bus.button_1 = 1;
        tick(12);
        chk("both_clear", 3'b000);
        press1(5);
        press1(5);
        press1(5);
        chk("count3", 3'b011);
        bus.button_1 = 0;
        tick(2);
        rst_n = 0;
        #1;
        chk("async_reset", 3'b000);
        tick(2);
        rst_n = 1;
        tick(20);
        chk("held_after_reset", 3'b001);
        bus.button_1 = 1;
        tick(12);
        chk("release_after_reset", 3'b001);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
